dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache with its controller.
- Sits between the core's memory stage (word requests) and the multi-cycle line-granular data memory.
- Serves hits combinationally in the request cycle.
- Serves misses through a FSM:
  - writes back the dirty victim if needed;
  - fetches the missing line;
  - completes the original access.

---
 rtl/dcache_ctrl.sv | 113 +++++++++++
 tb/tb_dcache_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache. Hits complete combinationally in IDLE;
// misses walk WB -> GAP_WB -> FILL -> GAP_FILL and then finish through the ordinary hit path.
module dcache_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int NUM_LINES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic [WORD_SIZE-3:0]   mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_SIZE-1:0]   mem_line_out,
  input  logic [LINE_SIZE-1:0]   mem_line_in,
  input  logic                   mem_ready
);

  localparam int WPL    = LINE_SIZE / WORD_SIZE;
  localparam int OFF_W  = $clog2(WPL);
  localparam int BYTE_W = $clog2(LINE_SIZE / 8);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - BYTE_W - IDX_W;
  localparam int MA_W   = WORD_SIZE - 2;

  typedef enum logic [2:0] {IDLE, WB, GAP_WB, FILL, GAP_FILL} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_SIZE-1:0]   data_q [NUM_LINES];

  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit, store_hit, wb_done, fill_done;
  logic                   unused_addr_bits;

  assign off = cpu_addr[BYTE_W-1:2];
  assign idx = cpu_addr[BYTE_W +: IDX_W];
  assign tag = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit       = cpu_req & valid_q[idx] & (tag_q[idx] == tag);
  assign store_hit = (state_q == IDLE) & hit & cpu_we;
  assign wb_done   = (state_q == WB) & mem_ready;
  assign fill_done = (state_q == FILL) & mem_ready;

  always_comb begin
    state_d      = state_q;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_line_out = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (!cpu_we) cpu_rdata = data_q[idx][off*WORD_SIZE +: WORD_SIZE];
        end else if (cpu_req) begin
          state_d = (valid_q[idx] & dirty_q[idx]) ? WB : FILL;
        end
      end
      WB: begin
        mem_write    = 1'b1;
        mem_addr     = MA_W'({tag_q[idx], idx});
        mem_line_out = data_q[idx];
        if (mem_ready) state_d = GAP_WB;
      end
      GAP_WB: state_d = FILL;
      FILL: begin
        mem_read = 1'b1;
        mem_addr = MA_W'({tag, idx});
        if (mem_ready) state_d = GAP_FILL;
      end
      GAP_FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (store_hit) dirty_q[idx] <= 1'b1;
      if (wb_done)   dirty_q[idx] <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset: a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (store_hit) data_q[idx][off*WORD_SIZE +: WORD_SIZE] <= cpu_wdata;
    if (fill_done) begin
      data_q[idx] <= mem_line_in;
      tag_q[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a fixed-latency line memory responder plus a flat word
// reference model; latency, write-back contents, reset abort and a random load/store mix.
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic         cpu_ready;
  logic [29:0]  mem_addr;
  logic         mem_read, mem_write, mem_ready = 1'b0;
  logic [127:0] mem_line_out, mem_line_in = '0;

  int n_cmp = 0, n_bad = 0;

  logic [127:0] mem_model [64];
  logic [31:0]  ref_mem   [256];
  logic         saw_read, saw_write;
  logic [29:0]  rd_addr, wr_addr;
  logic [127:0] wr_line;
  logic [31:0]  acc_rdata;
  int           acc_cycles;

  dcache_ctrl #(.WORD_SIZE(32), .LINE_SIZE(128), .NUM_LINES(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_line_out(mem_line_out), .mem_line_in(mem_line_in), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync_ref();
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 4; w++) ref_mem[l*4+w] = mem_model[l][w*32 +: 32];
  endtask

  // One core access, entered just after a rising edge; the request drops after completion.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic done;
    int   cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    saw_read = 1'b0; saw_write = 1'b0; done = 1'b0; cyc = 0; acc_rdata = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin
        done = 1'b1;
        acc_rdata = cpu_rdata;
      end
    end
    chk("ready_within_budget", 128'(done), 128'(1));
    acc_cycles = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Memory responder: mem_ready pulses LAT cycles after a request is first seen.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else begin
        chk("rd_wr_exclusive", 128'(mem_read & mem_write), 128'(0));
        if (mem_ready) begin
          chk("gap_after_txn", 128'(mem_read | mem_write), 128'(0));
          mem_ready = 1'b0;
          cnt = 0;
        end else if (mem_read | mem_write) begin
          cnt++;
          if (cnt == LAT) begin
            mem_ready = 1'b1;
            if (mem_read) begin
              mem_line_in = mem_model[mem_addr[5:0]];
              rd_addr = mem_addr;
              saw_read = 1'b1;
            end else begin
              mem_model[mem_addr[5:0]] = mem_line_out;
              wr_addr = mem_addr;
              wr_line = mem_line_out;
              saw_write = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic        we;
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 4; w++) mem_model[l][w*32 +: 32] = 32'hC0DE_0000 | 32'(l << 4) | 32'(w);
    mem_model[1] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    sync_ref();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", 128'(cpu_ready), 128'(0));
    chk("rst_cpu_rdata", 128'(cpu_rdata), 128'(0));
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_line_out", mem_line_out, 128'(0));
    @(posedge clk); #1 rst = 1'b1;

    // Cold load: FILL(3) + gap + hit after request cycle
    access(1'b0, 32'h10, '0);
    chk("cold_cycles", 128'(acc_cycles), 128'(6));
    chk("cold_rdata", 128'(acc_rdata), 128'(32'h1111_1111));
    chk("cold_rd_addr", 128'(rd_addr), 128'(1));
    chk("cold_no_wb", 128'(saw_write), 128'(0));

    access(1'b0, 32'h14, '0);
    chk("hit_cycles", 128'(acc_cycles), 128'(1));
    chk("hit_rdata", 128'(acc_rdata), 128'(32'h2222_2222));
    chk("hit_no_read", 128'(saw_read), 128'(0));

    access(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("store_hit_cycles", 128'(acc_cycles), 128'(1));

    // Dirty conflict: WB(3) + gap + FILL(3) + gap + hit
    access(1'b0, 32'h50, '0);
    chk("evict_cycles", 128'(acc_cycles), 128'(10));
    chk("evict_wr_addr", 128'(wr_addr), 128'(1));
    chk("evict_wr_line", wr_line, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF});
    chk("evict_rd_addr", 128'(rd_addr), 128'(5));
    chk("evict_rdata", 128'(acc_rdata), 128'(32'hC0DE_0050));

    access(1'b0, 32'h10, '0);
    chk("reload_cycles", 128'(acc_cycles), 128'(6));
    chk("reload_rdata", 128'(acc_rdata), 128'(32'hDEAD_BEEF));

    // Store miss to invalid index, later evicted dirty
    access(1'b1, 32'h20, 32'hCAFE_F00D);
    chk("stmiss_cycles", 128'(acc_cycles), 128'(6));
    chk("stmiss_rd_addr", 128'(rd_addr), 128'(2));
    chk("stmiss_no_wb", 128'(saw_write), 128'(0));
    access(1'b0, 32'hA0, '0);
    chk("stmiss_evict_cycles", 128'(acc_cycles), 128'(10));
    chk("stmiss_wr_addr", 128'(wr_addr), 128'(2));
    chk("stmiss_wr_line", wr_line, {32'hC0DE_0023, 32'hC0DE_0022, 32'hC0DE_0021, 32'hCAFE_F00D});
    chk("stmiss_evict_rdata", 128'(acc_rdata), 128'(32'hC0DE_00A0));

    // Store miss over a clean valid line of another tag: no write-back
    access(1'b0, 32'h30, '0);
    chk("clean_fill_rdata", 128'(acc_rdata), 128'(32'hC0DE_0030));
    access(1'b1, 32'h74, 32'h1234_5678);
    chk("clean_conf_cycles", 128'(acc_cycles), 128'(6));
    chk("clean_conf_no_wb", 128'(saw_write), 128'(0));
    access(1'b0, 32'h74, '0);
    chk("clean_conf_merge", 128'(acc_rdata), 128'(32'h1234_5678));
    chk("clean_conf_hit", 128'(acc_cycles), 128'(1));

    // Reset in the middle of a FILL
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(negedge clk); @(negedge clk);
    chk("fill_mem_read", 128'(mem_read), 128'(1));
    chk("fill_mem_addr", 128'(mem_addr), 128'(30'h10));
    #1 rst = 1'b0;
    #1;
    chk("abort_mem_read", 128'(mem_read), 128'(0));
    chk("abort_mem_addr", 128'(mem_addr), 128'(0));
    chk("abort_ready", 128'(cpu_ready), 128'(0));
    @(negedge clk); @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b1;
    sync_ref();
    access(1'b0, 32'h100, '0);
    chk("post_rst_cycles", 128'(acc_cycles), 128'(6));
    chk("post_rst_rdata", 128'(acc_rdata), 128'(32'hC0DE_0100));
    access(1'b0, 32'h74, '0);
    chk("post_rst_lost_store", 128'(acc_rdata), 128'(32'hC0DE_0071));

    // Random mix against the flat reference
    for (int i = 0; i < 500; i++) begin
      a  = 32'($urandom_range(0, 255)) << 2;
      d  = $urandom;
      we = 1'($urandom_range(0, 1));
      access(we, a, d);
      chk("rand_latency", 128'((acc_cycles == 1) || (acc_cycles == 6) || (acc_cycles == 10)), 128'(1));
      if (we) ref_mem[a[9:2]] = d;
      else chk("rand_load", 128'(acc_rdata), 128'(ref_mem[a[9:2]]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
